// File: rtl/mem_write_buffer_if.sv
// Memory-side write bus of the store buffer: request/payload out, acknowledge in.
interface mem_write_buffer_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          memReq;
    logic [AW-1:0] memAddr;
    logic [DW-1:0] memData;
    logic          memByte;
    logic          memAck;

    modport master (
        output memReq,
        output memAddr,
        output memData,
        output memByte,
        input  memAck
    );

    modport slave (
        input  memReq,
        input  memAddr,
        input  memData,
        input  memByte,
        output memAck
    );
endinterface

// File: rtl/mem_write_buffer.sv
// Write buffer between the cache store path and main memory, drained in push order.
// Define WBUF_FWD_EN to enable store-to-load forwarding; otherwise fwdHit/fwdData are tied to 0.
module mem_write_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wrEn,
    input  logic [AW-1:0]            wrAddr,
    input  logic [DW-1:0]            wrData,
    input  logic                     wrByte,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    input  logic [AW-1:0]            rdAddr,
    output logic                     fwdHit,
    output logic [DW-1:0]            fwdData,
    mem_write_buffer_if.master       mem
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {
        IDLE,
        REQ
    } state_t;

    state_t          state;
    logic            mem_req_q;
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_next;
    logic            push;
    logic            pop;

    logic [AW-1:0]   addr_mem    [DEPTH];
    logic [DW-1:0]   data_mem    [DEPTH];
    logic            is_byte_mem [DEPTH];

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

    // A store arriving while full is dropped even if the head pops this cycle.
    assign push = wrEn && !full;
    assign pop  = (state == REQ) && mem.memAck;

    always_comb begin
        count_next = count_q;
        case ({push, pop})
            2'b10:   count_next = count_q + CW'(1);
            2'b01:   count_next = count_q - CW'(1);
            default: count_next = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                tail <= tail + PW'(1);
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            count_q <= count_next;
        end
    end

    // Storage holds no reset; validity lives entirely in head/count.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[tail]    <= wrAddr;
            data_mem[tail]    <= wrData;
            is_byte_mem[tail] <= wrByte;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mem_req_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty) begin
                        state     <= REQ;
                        mem_req_q <= 1'b1;
                    end
                end
                REQ: begin
                    if (pop && (count_next == '0)) begin
                        state     <= IDLE;
                        mem_req_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Head stays put until the ack, so the payload is stable for the whole request.
    assign mem.memReq  = mem_req_q;
    assign mem.memAddr = addr_mem[head];
    assign mem.memData = data_mem[head];
    assign mem.memByte = is_byte_mem[head];

`ifdef WBUF_FWD_EN
    logic fwd_unused;
    assign fwd_unused = ^rdAddr[1:0];

    // Walk from oldest to youngest so the youngest matching entry wins.
    always_comb begin
        fwdHit  = 1'b0;
        fwdData = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CW'(i) < count_q) &&
                (addr_mem[head + PW'(i)][AW-1:2] == rdAddr[AW-1:2])) begin
                fwdHit = 1'b1;
                if (is_byte_mem[head + PW'(i)]) begin
                    fwdData = {{(DW-8){1'b0}}, data_mem[head + PW'(i)][7:0]};
                end else begin
                    fwdData = data_mem[head + PW'(i)];
                end
            end
        end
    end
`else
    logic fwd_unused;
    assign fwd_unused = ^rdAddr;
    assign fwdHit     = 1'b0;
    assign fwdData    = '0;
`endif

endmodule
